// File: rtl/fetch_pkg.sv
// Shared types and helpers for the prefetching instruction fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic               err;
  } fetch_entry_t;

  // RVC: anything whose two lowest bits are not 2'b11 is a 16-bit instruction.
  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Shift FIFO of fetched words: entry 0 is always the head, entry 1 the next word.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             clear,
  output fetch_entry_t     head,
  output fetch_entry_t     next,
  output logic [CNT_W-1:0] occupied
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic [CNT_W-1:0] wr_idx;

  always_comb begin
    // On a simultaneous pop the entries shift first, so the new word lands one slot lower.
    wr_idx = occ_q - CNT_W'(pop);
    occ_d  = occ_q + CNT_W'(push) - CNT_W'(pop);
    for (int i = 0; i < DEPTH - 1; i++) begin
      mem_d[i] = pop ? mem_q[i+1] : mem_q[i];
    end
    mem_d[DEPTH-1] = mem_q[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (CNT_W'(i) == wr_idx)) begin
        mem_d[i] = push_data;
      end
    end
    if (clear) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign head     = mem_q[0];
  assign next     = mem_q[1];
  assign occupied = occ_q;

  no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && !clear && (occ_q == CNT_W'(DEPTH))));

  no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(pop && (occ_q == '0)));

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Prefetching fetch stage: issues word requests, buffers responses and aligns
// 16/32-bit instructions onto a valid/ready output with PC and error tag.
module fetch_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          NUM_REQS   = 2,
  parameter int          FIFO_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               instr_req_o,
  input  logic               instr_gnt_i,
  output logic [31:0]        instr_addr_o,
  input  logic               instr_rvalid_i,
  input  logic [31:0]        instr_rdata_i,
  input  logic               instr_err_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [31:0]        out_pc_o,
  output logic               out_compressed_o,
  output logic               out_err_o,
  output logic               busy_o
);

  localparam int CW = $clog2(NUM_REQS + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  logic [31:0]        fetch_addr_q;
  logic [31:0]        out_pc_q;
  logic [CW-1:0]      outstanding_q;
  logic [CW-1:0]      outstanding_d;
  logic [CW-1:0]      discard_q;
  logic               run_q;
  logic [OW-1:0]      occupied;
  logic [SW-1:0]      inflight;
  fetch_entry_t       w0;
  fetch_entry_t       w1;
  fetch_entry_t       rsp_entry;
  logic               issue;
  logic               push;
  logic               rsp_drop;
  logic               pop;
  logic               fire;
  logic               al_valid;
  logic               al_comp;
  logic               al_err;
  logic               al_pop_word;
  logic [INSTR_W-1:0] al_instr;

  // Handshakes: the bus transfers a request on req & gnt (req/addr held until gnt)
  // and a response on rvalid; the output transfers on out_valid & out_ready.
  assign inflight    = SW'(occupied) + SW'(outstanding_q);
  assign instr_req_o = run_q && (outstanding_q < CW'(NUM_REQS))
                       && (inflight < SW'(FIFO_DEPTH)) && !redirect_i;
  assign issue       = instr_req_o && instr_gnt_i;
  assign rsp_drop    = instr_rvalid_i && (discard_q != '0);
  assign push        = instr_rvalid_i && (discard_q == '0);
  assign rsp_entry   = '{data: instr_rdata_i, err: instr_err_i};

  assign outstanding_d = outstanding_q + CW'(issue) - CW'(instr_rvalid_i);

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_data(rsp_entry),
    .pop      (pop),
    .clear    (redirect_i),
    .head     (w0),
    .next     (w1),
    .occupied (occupied)
  );

  always_comb begin
    al_instr    = w0.data;
    al_comp     = 1'b0;
    al_valid    = 1'b0;
    al_err      = w0.err;
    al_pop_word = 1'b0;
    if (!out_pc_q[1]) begin
      al_comp     = is_compressed(w0.data[1:0]);
      al_valid    = (occupied != '0);
      al_instr    = al_comp ? {16'h0000, w0.data[15:0]} : w0.data;
      al_pop_word = !al_comp;
    end else begin
      // Starting in the upper halfword always consumes W0.
      al_comp     = is_compressed(w0.data[17:16]);
      al_pop_word = 1'b1;
      if (al_comp) begin
        al_instr = {16'h0000, w0.data[31:16]};
        al_valid = (occupied != '0);
      end else begin
        al_instr = {w1.data[15:0], w0.data[31:16]};
        al_valid = (occupied >= OW'(2));
        al_err   = w0.err | w1.err;
      end
    end
    if (redirect_i) begin
      al_valid = 1'b0;
    end
  end

  assign fire = al_valid && out_ready_i;
  assign pop  = fire && al_pop_word;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_addr_q  <= PC_RESET & ~32'h3;
      out_pc_q      <= PC_RESET;
      outstanding_q <= '0;
      discard_q     <= '0;
      run_q         <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      outstanding_q <= outstanding_d;
      if (redirect_i) begin
        // Every response still owed after this cycle belongs to the old stream.
        discard_q    <= outstanding_d;
        fetch_addr_q <= redirect_pc_i & ~32'h3;
        out_pc_q     <= redirect_pc_i;
      end else begin
        if (rsp_drop) begin
          discard_q <= discard_q - CW'(1);
        end
        if (issue) begin
          fetch_addr_q <= fetch_addr_q + 32'd4;
        end
        if (fire) begin
          out_pc_q <= out_pc_q + (al_comp ? 32'd2 : 32'd4);
        end
      end
    end
  end

  assign instr_addr_o     = fetch_addr_q;
  assign busy_o           = (outstanding_q != '0);
  assign out_valid_o      = al_valid;
  assign out_instr_o      = al_valid ? al_instr : '0;
  assign out_pc_o         = al_valid ? out_pc_q : '0;
  assign out_compressed_o = al_valid && al_comp;
  assign out_err_o        = al_valid && al_err;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Self-checking bench for fetch_prefetch_buffer: in-order memory model plus
// an expected-instruction scoreboard derived from the memory image.
module tb_fetch_prefetch_buffer;

  logic        clk;
  logic        rstn;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        out_compressed_o;
  logic        out_err_o;
  logic        busy_o;

  fetch_prefetch_buffer #(
    .PC_RESET  (32'h0000_0080),
    .NUM_REQS  (2),
    .FIFO_DEPTH(3)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .instr_req_o     (instr_req_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_addr_o    (instr_addr_o),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .instr_err_i     (instr_err_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_instr_o     (out_instr_o),
    .out_pc_o        (out_pc_o),
    .out_compressed_o(out_compressed_o),
    .out_err_o       (out_err_o),
    .busy_o          (busy_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // memory image
  logic [31:0] mem_img [bit [31:0]];
  bit          err_img [bit [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a[25:2], 8'h13};
  endfunction

  function automatic logic err_word(input logic [31:0] a);
    if (err_img.exists(a)) return err_img[a];
    return 1'b0;
  endfunction

  // scoreboard: {err, compressed, pc, instr}
  logic [65:0] exp_q[$];

  task automatic gen_expect(input logic [31:0] start, input int n);
    logic [31:0] pc, w0, w1, ins;
    logic        c, e;
    pc = start;
    for (int i = 0; i < n; i++) begin
      w0 = mem_word(pc & ~32'h3);
      w1 = mem_word((pc & ~32'h3) + 32'h4);
      e  = err_word(pc & ~32'h3);
      if (!pc[1]) begin
        c   = (w0[1:0] != 2'b11);
        ins = c ? {16'h0000, w0[15:0]} : w0;
      end else begin
        c = (w0[17:16] != 2'b11);
        if (c) ins = {16'h0000, w0[31:16]};
        else begin
          ins = {w1[15:0], w0[31:16]};
          e   = e | err_word((pc & ~32'h3) + 32'h4);
        end
      end
      exp_q.push_back({e, c, pc, ins});
      pc = pc + (c ? 32'd2 : 32'd4);
    end
  endtask

  // memory model: in-order responses, lat cycles after the grant
  int          lat = 1;
  bit          gnt_rand = 0;
  int          bus_cyc = 0;
  int          max_outs = 0;
  logic [31:0] pend_addr[$];
  int          pend_cyc[$];
  logic        acc, rv, req_held, seen_first;
  logic [31:0] acc_addr, held_addr, first_addr;

  initial begin
    instr_gnt_i    = 1'b1;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    req_held       = 1'b0;
    seen_first     = 1'b0;
    first_addr     = '0;
  end

  always begin
    @(negedge clk);
    acc      = rstn && instr_req_o && instr_gnt_i;
    acc_addr = instr_addr_o;
    rv       = rstn && instr_rvalid_i;
    if (req_held && !redirect_i) begin
      check("req_hold", instr_req_o, 1);
      check("addr_hold", instr_addr_o, held_addr);
    end
    req_held  = rstn && instr_req_o && !instr_gnt_i;
    held_addr = instr_addr_o;
    @(posedge clk);
    #1;
    bus_cyc++;
    if (rv && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_cyc.pop_front());
    end
    if (acc) begin
      if (!seen_first) begin
        first_addr = acc_addr;
        seen_first = 1'b1;
      end
      pend_addr.push_back(acc_addr);
      pend_cyc.push_back(bus_cyc);
    end
    if (pend_addr.size() > max_outs) max_outs = pend_addr.size();
    if (pend_addr.size() > 0 && (bus_cyc - pend_cyc[0]) >= lat - 1) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_word(pend_addr[0]);
      instr_err_i    = err_word(pend_addr[0]);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
    end
    instr_gnt_i = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // output monitor: drives ready, compares every accepted instruction
  bit          ready_rand = 0;
  int          mon_cyc = 0;
  int          hold_until = 0;
  logic        hold_seen;
  logic [31:0] hold_pc, hold_instr;
  logic [65:0] exp_e;

  initial begin
    out_ready_i = 1'b0;
    hold_seen   = 1'b0;
  end

  always begin
    @(negedge clk);
    mon_cyc++;
    if (mon_cyc < hold_until) begin
      out_ready_i = 1'b0;
      if (hold_seen && out_valid_o) begin
        check("stall_pc", out_pc_o, hold_pc);
        check("stall_instr", out_instr_o, hold_instr);
      end
      hold_seen  = out_valid_o;
      hold_pc    = out_pc_o;
      hold_instr = out_instr_o;
    end else begin
      hold_seen   = 1'b0;
      out_ready_i = (exp_q.size() > 0) && (!ready_rand || $urandom_range(0, 3) != 0);
    end
    if (out_valid_o && out_ready_i) begin
      exp_e = exp_q.pop_front();
      check("out_pc", out_pc_o, exp_e[63:32]);
      check("out_instr", out_instr_o, exp_e[31:0]);
      check("out_compressed", out_compressed_o, exp_e[64]);
      check("out_err", out_err_o, exp_e[65]);
    end
  end

  // driver tasks
  task automatic do_redirect(input logic [31:0] pc, input int n);
    @(posedge clk);
    #1;
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    exp_q.delete();
    gen_expect(pc, n);
    #1;
    check("redir_valid", out_valid_o, 0);
    check("redir_req", instr_req_o, 0);
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    check("redir_addr", instr_addr_o, pc & ~32'h3);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    check(tag, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          k;
    logic [31:0] pc;
    rstn          = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", instr_req_o, 0);
    check("rst_addr", instr_addr_o, 32'h80);
    check("rst_valid", out_valid_o, 0);
    check("rst_pc", out_pc_o, 0);
    check("rst_instr", out_instr_o, 0);
    check("rst_busy", busy_o, 0);

    // straight-line 32-bit code from the reset PC
    gen_expect(32'h80, 8);
    rstn = 1'b1;
    wait_drain("s1_drain");
    check("first_addr", first_addr, 32'h80);

    // two compressed instructions in one word
    mem_img[32'h80] = 32'h0001_4505;
    mem_img[32'h84] = 32'h0000_0013;
    do_redirect(32'h80, 6);
    wait_drain("s2_drain");

    // 32-bit instruction straddling two words, slow memory
    mem_img[32'h80] = 32'h0093_0001;
    mem_img[32'h84] = 32'hABCD_0000;
    lat = 4;
    do_redirect(32'h80, 5);
    wait_drain("s3_drain");

    // error on the word holding the upper half of the straddling instruction
    err_img[32'h84] = 1'b1;
    lat = 1;
    do_redirect(32'h80, 5);
    wait_drain("s6_drain");
    err_img.delete();

    // redirect with two requests in flight
    mem_img[32'h100] = 32'h0001_0000;
    lat = 4;
    do_redirect(32'h80, 0);
    k = 0;
    while (pend_addr.size() != 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("s4_two_outstanding", pend_addr.size(), 2);
    do_redirect(32'h102, 6);
    wait_drain("s4_drain");

    // downstream stall: request stops once the buffer is committed
    lat = 1;
    hold_until = mon_cyc + 14;
    do_redirect(32'h200, 10);
    repeat (10) @(posedge clk);
    #1;
    check("stall_req", instr_req_o, 0);
    check("stall_busy", busy_o, 0);
    check("stall_valid", out_valid_o, 1);
    wait_drain("s5_drain");

    // random code, random bus and ready timing, occasional mid-stream redirect
    gnt_rand   = 1;
    ready_rand = 1;
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 16; a++) begin
        mem_img[32'h300 + 32'(4 * a)] = $urandom();
        err_img[32'h300 + 32'(4 * a)] = ($urandom_range(0, 5) == 0);
      end
      lat = $urandom_range(1, 3);
      pc  = 32'h300 + 32'(2 * $urandom_range(0, 7));
      do_redirect(pc, 16);
      if (r % 2 == 1) begin
        k = 0;
        while (exp_q.size() > 10 && k < 500) begin
          @(negedge clk);
          k++;
        end
        check("rnd_progress", exp_q.size() <= 10, 1);
        do_redirect(32'h300 + 32'(2 * $urandom_range(0, 15)), 12);
      end
      wait_drain("rnd_drain");
    end

    check("max_outstanding", max_outs, 2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
